id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS datapath. It sits directly downstream of the instruction decoder and register file. It captures the decoder control word, operand data and register fields each cycle, inserts a bubble on a load-use hazard or branch flush, and drives `stall_o` back to the PC and IF/ID registers.

## Interface
- `DATA_W`, 32, width of PC, operand and immediate paths
- `BUBBLE_CTRL`, 15'h0040, control word loaded for a bubble: all zero except Jump (bit 6), which is active-low (1 = no jump)

Ports:
- `clk_i` in 1: clock; all state updates on the rising edge
- `rst_i` in 1: reset, synchronous, active-high
- `ctrl_i` in 15: decoder control word {RegWrite[14], ALU_op[13:11], ALUSrc[10], RegDst[9:8], Branch[7], Jump[6], MemRead[5], MemWrite[4], MemToReg[3:2], Branchtype[1:0]}
- `instr_i` in 32: ID-stage instruction
- `id_valid_i` in 1: ID holds a real instruction
- `pc_plus4_i` in DATA_W: PC+4 of the ID instruction
- `rs_data_i`, `rt_data_i` in DATA_W: register file read data
- `imm_i` in DATA_W: sign-extended immediate
- `flush_i` in 1: taken branch/jump resolved downstream; kill the ID instruction
- `ctrl_o` out 15: registered control word
- `valid_o` out 1: ID/EX holds a real instruction
- `pc_plus4_o`, `rs_data_o`, `rt_data_o`, `imm_o` out DATA_W: registered data
- `rs_o`, `rt_o`, `rd_o` out 5: registered instr[25:21], [20:16], [15:11]
- `shamt_o` out 5, `funct_o` out 6: registered instr[10:6], [5:0]
- `stall_o` out 1: combinational; hold PC and IF/ID this cycle
- `bubble_cnt_o` out 16: bubble counter (see Configuration)

## Operation
- Load-use hazard detection (`hz`): `hz` = `valid_o` & `ctrl_o`[5] & `id_valid_i` & (`rt_o` != 0) & ((`rt_o` == instr_i[25:21]) | (`rt_o` == instr_i[20:16] & `uses_rt`)).
- `uses_rt` = !(`ctrl_i`[10] & !`ctrl_i`[4]). ALU-immediate ops and loads do not read rt; sw does.
- `stall_o` = `hz` & !`flush_i`.
- Next-state priority, evaluated per edge:
  1. `rst_i`: `ctrl_o` = `BUBBLE_CTRL`; `valid_o` = 0; all data and field outputs = 0.
  2. `flush_i`: bubble. `ctrl_o` = `BUBBLE_CTRL`, `valid_o` = 0; data and field outputs are don't-care but shall load from inputs.
  3. `stall_o`: bubble, same as flush. The ID instruction is held upstream and re-presented next cycle.
  4. Otherwise: load all inputs. `valid_o` = `id_valid_i`. `ctrl_o` = `ctrl_i` if `id_valid_i`, else `BUBBLE_CTRL`.
- A stall lasts at most 1 cycle, because the inserted bubble has MemRead = 0.
- Back-to-back loads each stall independently.
- No arithmetic on the datapath. Every field is a pure register copy.

## Timing
- Latency: 1 cycle, from ID inputs to all registered outputs.
- `stall_o` is combinational from registered ID/EX state and same-cycle ID inputs. It has no path from `rst_i`.
- Upstream must honour `stall_o` in the same cycle it is asserted.
- `flush_i` and `hz` both high: flush wins, `stall_o` = 0, one bubble.
- Reset mid-stall: next cycle `stall_o` = 0 (because `valid_o` = 0) and the counter = 0.
- `id_valid_i` = 0 never raises `stall_o`.

## Configuration
- `ID_EX_PERF_EN` defined:
  - `bubble_cnt_o` increments by 1 on every edge that loads a bubble due to `flush_i` or `stall_o`.
  - It saturates at 16'hFFFF and clears on `rst_i`.
- Not defined: `bubble_cnt_o` is constant 0 and no counter flops are built.

## Test plan
- Reset: hold `rst_i` = 1 for 2 cycles with random inputs. Required: `ctrl_o` = 15'h0040, `valid_o` = 0, all other outputs 0, `stall_o` = 0.
- Pass-through:
  - Stimulus: `ctrl_i` = 15'h4340 (add), `instr_i` = 32'h012A4020, data 1/2/3/4, valid.
  - Required, next cycle: `ctrl_o` = 15'h4340, `rs_o` = 9, `rt_o` = 10, `rd_o` = 8, `funct_o` = 6'h20, `valid_o` = 1, no stall.
- Load-use:
  - Stimulus: lw $8 in ID/EX, dependent add $9,$8,$10 in ID.
  - Required: `stall_o` = 1 for 1 cycle; next cycle `ctrl_o` = 15'h0040; following cycle the add loads and `stall_o` = 0.
- rt masking:
  - Stimulus: lw $8 in ID/EX, addi $8,$9,1 in ID (rt field = 8).
  - Required: `stall_o` = 0.
- Flush over stall:
  - Stimulus: load-use condition plus `flush_i` = 1.
  - Required: `stall_o` = 0, bubble loaded, `bubble_cnt_o` increments by 1 (with the macro).
- Counter saturation (macro on): force 70000 bubble cycles. Required: `bubble_cnt_o` = 16'hFFFF, then 0 after `rst_i`.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection for the 5-stage MIPS datapath.
// Captures the decoder control word, operand data and register fields every cycle. A bubble
// is inserted on a load-use hazard (stall_o) or a downstream flush (flush_i).
// Optional feature: define ID_EX_PERF_EN to build a saturating 16-bit bubble counter on
// bubble_cnt_o. When it is not defined, bubble_cnt_o is tied to zero and no counter flops exist.
module id_ex_stage #(
    parameter int unsigned DATA_W      = 32,
    parameter logic [14:0] BUBBLE_CTRL = 15'h0040
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [14:0]       ctrl_i,
    input  logic [31:0]       instr_i,
    input  logic              id_valid_i,
    input  logic [DATA_W-1:0] pc_plus4_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic              flush_i,
    output logic [14:0]       ctrl_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] pc_plus4_o,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [4:0]        rs_o,
    output logic [4:0]        rt_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        shamt_o,
    output logic [5:0]        funct_o,
    output logic              stall_o,
    output logic [15:0]       bubble_cnt_o
);

    // Pipeline register state
    logic [14:0]       ctrl_q,  ctrl_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] pc_q,    pc_d;
    logic [DATA_W-1:0] rsd_q,   rsd_d;
    logic [DATA_W-1:0] rtd_q,   rtd_d;
    logic [DATA_W-1:0] imm_q,   imm_d;
    logic [4:0]        rs_q,    rs_d;
    logic [4:0]        rt_q,    rt_d;
    logic [4:0]        rd_q,    rd_d;
    logic [4:0]        shamt_q, shamt_d;
    logic [5:0]        funct_q, funct_d;

    logic uses_rt;
    logic hz;
    logic stall;
    logic bubble;

    // Opcode bits are decoded upstream; they are not needed here.
    logic unused_opcode;
    assign unused_opcode = ^instr_i[31:26];

    // Load-use hazard: a load in ID/EX whose destination (rt) is read by the ID instruction
    always_comb begin
        uses_rt = !(ctrl_i[10] && !ctrl_i[4]);
        hz      = valid_q && ctrl_q[5] && id_valid_i && (rt_q != 5'd0) &&
                  ((rt_q == instr_i[25:21]) || ((rt_q == instr_i[20:16]) && uses_rt));
        stall   = hz && !flush_i;
        bubble  = flush_i || stall;
    end

    // Next-state: data always loads; control/valid become a bubble on flush or stall
    always_comb begin
        ctrl_d  = BUBBLE_CTRL;
        valid_d = 1'b0;
        pc_d    = pc_plus4_i;
        rsd_d   = rs_data_i;
        rtd_d   = rt_data_i;
        imm_d   = imm_i;
        rs_d    = instr_i[25:21];
        rt_d    = instr_i[20:16];
        rd_d    = instr_i[15:11];
        shamt_d = instr_i[10:6];
        funct_d = instr_i[5:0];
        if (!bubble) begin
            valid_d = id_valid_i;
            if (id_valid_i) begin
                ctrl_d = ctrl_i;
            end
        end
    end

    // Pipeline register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q  <= BUBBLE_CTRL;
            valid_q <= 1'b0;
            pc_q    <= '0;
            rsd_q   <= '0;
            rtd_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            shamt_q <= '0;
            funct_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rsd_q   <= rsd_d;
            rtd_q   <= rtd_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            shamt_q <= shamt_d;
            funct_q <= funct_d;
        end
    end

`ifdef ID_EX_PERF_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating count of edges that load a bubble
    always_comb begin
        cnt_d = cnt_q;
        if (bubble && (cnt_q != '1)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Bubble counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bubble_cnt_o = cnt_q;
`else
    assign bubble_cnt_o = '0;
`endif

    assign ctrl_o     = ctrl_q;
    assign valid_o    = valid_q;
    assign pc_plus4_o = pc_q;
    assign rs_data_o  = rsd_q;
    assign rt_data_o  = rtd_q;
    assign imm_o      = imm_q;
    assign rs_o       = rs_q;
    assign rt_o       = rt_q;
    assign rd_o       = rd_q;
    assign shamt_o    = shamt_q;
    assign funct_o    = funct_q;
    assign stall_o    = stall;

endmodule
